// File: rtl/fdtd_axi_pkg.sv
// Shared AXI definitions for the FDTD register-file word adapters (read and write).
package fdtd_axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    WAIT_AWVALID = 2'd0,
    WAIT_WVALID  = 2'd1,
    SEND_RESP    = 2'd2
  } wr_state_e;

  // Upper byte-address bit of the word address field ADDR[msb:2].
  function automatic int unsigned word_addr_msb(input int unsigned word_addr_width);
    return word_addr_width + 1;
  endfunction

endpackage

// File: rtl/fdtd_reg_word_wr.sv
// AXI4 write-channel slave converting AW/W/B traffic into single-cycle
// word-write strobes for the FDTD register file. One transaction at a time.
module fdtd_reg_word_wr
  import fdtd_axi_pkg::*;
#(
  parameter int unsigned AXI4_ADDR_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 32,
  parameter int unsigned AXI4_ID_WIDTH   = 16,
  parameter int unsigned AXI4_USER_WIDTH = 10,
  parameter int unsigned AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8,
  parameter int unsigned WORD_ADDR_WIDTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,

  input  logic [AXI4_ID_WIDTH-1:0]   AWID_i,
  input  logic [AXI4_ADDR_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                 AWLEN_i,
  input  logic [2:0]                 AWSIZE_i,
  input  logic [1:0]                 AWBURST_i,
  input  logic                       AWLOCK_i,
  input  logic [3:0]                 AWCACHE_i,
  input  logic [2:0]                 AWPROT_i,
  input  logic [3:0]                 AWREGION_i,
  input  logic [AXI4_USER_WIDTH-1:0] AWUSER_i,
  input  logic [3:0]                 AWQOS_i,
  input  logic                       AWVALID_i,
  output logic                       AWREADY_o,

  input  logic [AXI4_DATA_WIDTH-1:0] WDATA_i,
  input  logic [AXI_STRB_WIDTH-1:0]  WSTRB_i,
  input  logic                       WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0] WUSER_i,
  input  logic                       WVALID_i,
  output logic                       WREADY_o,

  output logic [AXI4_ID_WIDTH-1:0]   BID_o,
  output logic [1:0]                 BRESP_o,
  output logic [AXI4_USER_WIDTH-1:0] BUSER_o,
  output logic                       BVALID_o,
  input  logic                       BREADY_i,

  output logic                       wvalid_o,
  output logic [WORD_ADDR_WIDTH-1:0] word_addr_o,
  output logic [AXI4_DATA_WIDTH-1:0] data_o,
  output logic [AXI_STRB_WIDTH-1:0]  strb_o
);

  localparam int unsigned ADDR_MSB = word_addr_msb(WORD_ADDR_WIDTH);

  wr_state_e                  state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]                 awlen_q, awlen_d;
  logic [AXI4_ID_WIDTH-1:0]   bid_q, bid_d;

  // Sideband and upper address bits have no effect on the register write.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR_i, AWSIZE_i, AWBURST_i, AWLOCK_i, AWCACHE_i,
                           AWPROT_i, AWREGION_i, AWUSER_i, AWQOS_i, WLAST_i, WUSER_i};

  // State and transaction-context registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= WAIT_AWVALID;
      awaddr_q <= '0;
      awlen_q  <= '0;
      bid_q    <= '0;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      bid_q    <= bid_d;
    end
  end

  // Next-state logic and handshake outputs; every burst beat targets the same word.
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    bid_d     = bid_q;
    AWREADY_o = 1'b0;
    WREADY_o  = 1'b0;
    BVALID_o  = 1'b0;
    wvalid_o  = 1'b0;
    case (state_q)
      WAIT_AWVALID: begin
        AWREADY_o = 1'b1;
        if (AWVALID_i) begin
          awaddr_d = AWADDR_i[ADDR_MSB:2];
          awlen_d  = AWLEN_i;
          bid_d    = AWID_i;
          state_d  = WAIT_WVALID;
        end
      end
      WAIT_WVALID: begin
        WREADY_o = 1'b1;
        if (WVALID_i) begin
          wvalid_o = 1'b1;
          if (awlen_q == 8'd0) begin
            state_d = SEND_RESP;
          end else begin
            awlen_d = awlen_q - 8'd1;
          end
        end
      end
      SEND_RESP: begin
        BVALID_o = 1'b1;
        if (BREADY_i) begin
          state_d = WAIT_AWVALID;
        end
      end
      default: state_d = WAIT_AWVALID;
    endcase
  end

  assign BID_o       = bid_q;
  assign BRESP_o     = OKAY;
  assign BUSER_o     = '0;
  assign word_addr_o = awaddr_q;
  assign data_o      = WDATA_i;
  assign strb_o      = WSTRB_i;

endmodule

// File: tb/tb_fdtd_reg_word_wr.sv
// Scoreboard bench for fdtd_reg_word_wr: stimulus pushes expected word writes
// and B responses; a negedge monitor pops and compares them.
module tb_fdtd_reg_word_wr;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] AWID_i;
  logic [31:0] AWADDR_i;
  logic [7:0]  AWLEN_i;
  logic        AWVALID_i;
  logic        AWREADY_o;
  logic [31:0] WDATA_i;
  logic [3:0]  WSTRB_i;
  logic        WLAST_i;
  logic        WVALID_i;
  logic        WREADY_o;
  logic [15:0] BID_o;
  logic [1:0]  BRESP_o;
  logic [9:0]  BUSER_o;
  logic        BVALID_o;
  logic        BREADY_i;
  logic        wvalid_o;
  logic [3:0]  word_addr_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  always #5 ACLK = ~ACLK;

  fdtd_reg_word_wr #(
    .AXI4_ADDR_WIDTH(32),
    .AXI4_DATA_WIDTH(32),
    .AXI4_ID_WIDTH  (16),
    .AXI4_USER_WIDTH(10),
    .WORD_ADDR_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i),
    .AWSIZE_i(3'd2), .AWBURST_i(2'd1), .AWLOCK_i(1'b0), .AWCACHE_i(4'd0),
    .AWPROT_i(3'd0), .AWREGION_i(4'd0), .AWUSER_i(10'd0), .AWQOS_i(4'd0),
    .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WUSER_i(10'd0),
    .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
    .BID_o(BID_o), .BRESP_o(BRESP_o), .BUSER_o(BUSER_o), .BVALID_o(BVALID_o),
    .BREADY_i(BREADY_i),
    .wvalid_o(wvalid_o), .word_addr_o(word_addr_o), .data_o(data_o), .strb_o(strb_o)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wexp_t;

  wexp_t       wq[$];
  logic [15:0] bq[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  cur_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every word-write pulse and every B handshake must match the head of its queue.
  always @(negedge ACLK) begin
    wexp_t       e;
    logic [15:0] id;
    if (wvalid_o === 1'b1) begin
      if (wq.size() == 0) begin
        check("spurious_wvalid", {63'd0, wvalid_o}, 64'd0);
      end else begin
        e = wq.pop_front();
        check("word_addr", {60'd0, word_addr_o}, {60'd0, e.addr});
        check("data", {32'd0, data_o}, {32'd0, e.data});
        check("strb", {60'd0, strb_o}, {60'd0, e.strb});
      end
    end
    if (BVALID_o === 1'b1 && BREADY_i === 1'b1) begin
      if (bq.size() == 0) begin
        check("spurious_bresp", {63'd0, BVALID_o}, 64'd0);
      end else begin
        id = bq.pop_front();
        check("bid", {48'd0, BID_o}, {48'd0, id});
        check("bresp", {62'd0, BRESP_o}, 64'd0);
        check("buser", {54'd0, BUSER_o}, 64'd0);
      end
    end
  end

  task automatic aw(input logic [31:0] addr, input logic [7:0] len, input logic [15:0] id,
                    output int waited);
    int n = 0;
    AWVALID_i = 1'b1; AWADDR_i = addr; AWLEN_i = len; AWID_i = id;
    @(negedge ACLK);
    while (AWREADY_o !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) check("aw_timeout", 64'd1, 64'd0);
    cur_addr = addr[5:2];
    @(posedge ACLK); #1;
    AWVALID_i = 1'b0;
    waited = n;
  endtask

  task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, output int waited);
    int n = 0;
    wexp_t e;
    e.addr = cur_addr; e.data = data; e.strb = strb;
    wq.push_back(e);
    WVALID_i = 1'b1; WDATA_i = data; WSTRB_i = strb;
    @(negedge ACLK);
    while (WREADY_o !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) check("w_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
    WVALID_i = 1'b0;
    waited = n;
  endtask

  task automatic bresp(input int delay, input logic [15:0] id);
    int n = 0;
    bq.push_back(id);
    BREADY_i = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge ACLK);
      check("bvalid_hold", {63'd0, BVALID_o}, 64'd1);
      check("bid_hold", {48'd0, BID_o}, {48'd0, id});
      check("awready_in_resp", {63'd0, AWREADY_o}, 64'd0);
      @(posedge ACLK); #1;
    end
    BREADY_i = 1'b1;
    @(negedge ACLK);
    while (BVALID_o !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) check("b_timeout", 64'd1, 64'd0);
    @(posedge ACLK); #1;
    BREADY_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, {63'd0, AWREADY_o}, 64'd1);
    check({tag, "_wready"}, {63'd0, WREADY_o}, 64'd0);
    check({tag, "_bvalid"}, {63'd0, BVALID_o}, 64'd0);
    check({tag, "_wvalid"}, {63'd0, wvalid_o}, 64'd0);
    check({tag, "_bid"}, {48'd0, BID_o}, 64'd0);
    check({tag, "_word_addr"}, {60'd0, word_addr_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] d4 [4];
    d4[0] = 32'h11111111; d4[1] = 32'h22222222; d4[2] = 32'h33333333; d4[3] = 32'h44444444;
    ARESETn = 1'b0; AWVALID_i = 1'b0; AWID_i = '0; AWADDR_i = '0; AWLEN_i = '0;
    WVALID_i = 1'b0; WDATA_i = '0; WSTRB_i = '0; WLAST_i = 1'b0; BREADY_i = 1'b0;
    cur_addr = '0;
    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Single beat: addr 0x1C -> word 7, ID 5.
    aw(32'h1C, 8'd0, 16'h5, w);
    check("t1_aw_wait", w, 0);
    wbeat(32'hDEADBEEF, 4'hF, w);
    check("t1_w_wait", w, 0);
    check("t1_bvalid", {63'd0, BVALID_o}, 64'd1);
    check("t1_bid", {48'd0, BID_o}, 64'h5);
    check("t1_bresp", {62'd0, BRESP_o}, 64'd0);
    bresp(0, 16'h5);

    // Four beats held back-to-back to word 2; B only after the last.
    aw(32'h08, 8'd3, 16'h21, w);
    for (int i = 0; i < 4; i++) begin
      wbeat(d4[i], 4'(i + 1), w);
      check("t2_bvalid", {63'd0, BVALID_o}, (i == 3) ? 64'd1 : 64'd0);
    end
    bresp(0, 16'h21);

    // AW and W together in an idle cycle: W must wait one cycle.
    AWVALID_i = 1'b1; AWADDR_i = 32'h14; AWLEN_i = 8'd0; AWID_i = 16'h33;
    WVALID_i = 1'b1; WDATA_i = 32'hCAFEF00D; WSTRB_i = 4'h0;
    @(negedge ACLK);
    check("t3_wready_idle", {63'd0, WREADY_o}, 64'd0);
    check("t3_wvalid_idle", {63'd0, wvalid_o}, 64'd0);
    check("t3_awready_idle", {63'd0, AWREADY_o}, 64'd1);
    cur_addr = 4'd5;
    @(posedge ACLK); #1;
    AWVALID_i = 1'b0;
    wbeat(32'hCAFEF00D, 4'h0, w);
    check("t3_w_wait", w, 0);
    bresp(0, 16'h33);

    // BREADY held low 5 cycles with a new AW pending.
    aw(32'h24, 8'd0, 16'h44, w);
    wbeat(32'h0BADC0DE, 4'h3, w);
    AWVALID_i = 1'b1; AWADDR_i = 32'h30; AWLEN_i = 8'd1; AWID_i = 16'h55;
    bresp(5, 16'h44);
    aw(32'h30, 8'd1, 16'h55, w);
    check("t4_aw_after_b", w, 0);

    // Two beats separated by three idle cycles.
    wbeat(32'hA5A5A5A5, 4'hC, w);
    repeat (3) @(posedge ACLK);
    #1;
    check("t5_wready_gap", {63'd0, WREADY_o}, 64'd1);
    wbeat(32'h5A5A5A5A, 4'h1, w);
    bresp(0, 16'h55);

    // Reset while beat 2 of 4 is presented: aborts, no B.
    aw(32'h3C, 8'd3, 16'h66, w);
    wbeat(32'h01020304, 4'hF, w);
    WVALID_i = 1'b1; WDATA_i = 32'h05060708; ARESETn = 1'b0;
    @(negedge ACLK);
    check_reset_outputs("t6");
    @(posedge ACLK); #1;
    WVALID_i = 1'b0; ARESETn = 1'b1;
    repeat (2) begin
      @(negedge ACLK);
      check("t6_no_bvalid", {63'd0, BVALID_o}, 64'd0);
    end
    @(posedge ACLK); #1;
    aw(32'h04, 8'd0, 16'h77, w);
    wbeat(32'h87654321, 4'h6, w);
    bresp(0, 16'h77);

    // AWLEN=255: 256 beats, B only after the last.
    aw(32'h2C, 8'd255, 16'hABCD, w);
    for (int i = 0; i < 256; i++) begin
      wbeat(32'h1000 + i, 4'hF, w);
      if (i >= 254) check("t7_bvalid", {63'd0, BVALID_o}, (i == 255) ? 64'd1 : 64'd0);
    end
    bresp(0, 16'hABCD);

    repeat (3) @(negedge ACLK);
    check("wq_drained", wq.size(), 0);
    check("bq_drained", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fdtd_reg_word_wr.md
Name: fdtd_reg_word_wr

Overview:
AXI4 write-channel slave that turns AW/W/B traffic into simple single-cycle word-write strobes (address, data, byte strobe) for the FDTD register file. It is the write-side counterpart of the FDTD word-read adapter. Both adapters share the same word addressing (ADDR[WORD_ADDR_WIDTH+1:2]). One transaction is handled at a time: no outstanding writes, and no interleaving of AW and W acceptance.

Parameters:
AXI4_ADDR_WIDTH, 32, AXI address width
AXI4_DATA_WIDTH, 32, AXI data width
AXI4_ID_WIDTH, 16, AXI ID width
AXI4_USER_WIDTH, 10, AXI user-signal width
AXI_STRB_WIDTH, AXI4_DATA_WIDTH/8, write-strobe width
WORD_ADDR_WIDTH, 4, register word-address width

Ports:
ACLK  in  1  clock; one clock domain
ARESETn  in  1  reset, asynchronous, active-low
AWID_i  in  AXI4_ID_WIDTH  write transaction ID
AWADDR_i  in  AXI4_ADDR_WIDTH  byte address; bits [WORD_ADDR_WIDTH+1:2] used
AWLEN_i  in  8  beats-1
AWSIZE_i/AWBURST_i/AWLOCK_i/AWCACHE_i/AWPROT_i/AWREGION_i/AWUSER_i/AWQOS_i  in  3/2/1/4/3/4/AXI4_USER_WIDTH/4  accepted, ignored
AWVALID_i  in  1  address valid
AWREADY_o  out  1  address ready
WDATA_i  in  AXI4_DATA_WIDTH  write data
WSTRB_i  in  AXI_STRB_WIDTH  byte strobes
WLAST_i  in  1  last beat; ignored, beat count from AWLEN
WUSER_i  in  AXI4_USER_WIDTH  ignored
WVALID_i  in  1  data valid
WREADY_o  out  1  data ready
BID_o  out  AXI4_ID_WIDTH  latched AWID
BRESP_o  out  2  always OKAY (2'b00)
BUSER_o  out  AXI4_USER_WIDTH  always 0
BVALID_o  out  1  response valid
BREADY_i  in  1  response ready
wvalid_o  out  1  word-write strobe, one cycle per accepted W beat
word_addr_o  out  WORD_ADDR_WIDTH  latched word address
data_o  out  AXI4_DATA_WIDTH  equals WDATA_i
strb_o  out  AXI_STRB_WIDTH  equals WSTRB_i

Behaviour:
- Registers: r_awaddr (word address), r_awlen (8b), r_bid. All reset to 0.
- FSM state r_WS (2b) has three states: WAIT_AWVALID (reset), WAIT_WVALID, SEND_RESP. The illegal code returns to WAIT_AWVALID.
- WAIT_AWVALID:
  - AWREADY_o=1, WREADY_o=0, BVALID_o=0.
  - On AWVALID_i: latch AWADDR_i[WORD_ADDR_WIDTH+1:2], AWLEN_i and AWID_i, then go to WAIT_WVALID.
  - A W beat presented in the same cycle is not accepted.
- WAIT_WVALID:
  - WREADY_o=1; AWREADY_o=0.
  - On WVALID_i: wvalid_o=1 in the same cycle (combinational), with data_o/strb_o taken straight from WDATA_i/WSTRB_i and word_addr_o=r_awaddr.
  - If r_awlen==0, go to SEND_RESP. Otherwise decrement r_awlen and stay.
  - Every beat of a burst writes the same latched word address (FIXED semantics regardless of AWBURST).
  - strb_o==0 still produces a wvalid_o pulse; the consumer masks it.
- SEND_RESP:
  - BVALID_o=1, BID_o=r_bid, BRESP_o=OKAY.
  - On BREADY_i, go to WAIT_AWVALID. Otherwise hold BVALID_o and BID_o stable.
- Latency: AW handshake in cycle N, first W beat accepted no earlier than N+1, BVALID_o asserted in the cycle after the last W handshake. A single-beat write with all valids held takes 3 cycles from AW to B.
- wvalid_o is asserted only when WVALID_i && WREADY_o, so there is never more than one pulse per beat.
- Reset outputs: AWREADY_o=1 (state WAIT_AWVALID), WREADY_o=0, BVALID_o=0, wvalid_o=0, BID_o=0, word_addr_o=0.
- Reset asserted mid-burst or mid-response aborts the transaction with no B response. Writes already pulsed remain done.
- AWLEN=255: 256 beats, and r_awlen does not wrap below 0.

Decomposition:
- Shared package fdtd_axi_pkg holds:
  - AXI response constants OKAY/EXOKAY/SLVERR/DECERR
  - the write-FSM enum type
  - the word-address extraction width helper
- These are shared with the read adapter.
- No sub-module; a single flat module is the natural structure.

Test Plan:
- Reset, then AWADDR=0x1C, AWLEN=0, AWID=0x5 -> next cycle, WDATA=0xDEADBEEF with WSTRB=0xF gives wvalid_o=1, word_addr_o=7, data_o=0xDEADBEEF. The following cycle gives BVALID=1, BID=0x5, BRESP=0.
- AWLEN=3, addr 0x08, WVALID held with 4 different data words -> 4 wvalid_o pulses, all with word_addr_o=2. BVALID asserts only after the 4th beat.
- AWVALID and WVALID both asserted in the same idle cycle -> WREADY=0 in that cycle and no wvalid_o pulse. The beat is accepted one cycle later.
- BREADY held low for 5 cycles -> BVALID and BID stay stable, AWREADY stays 0, and a new AWVALID is not accepted until the B handshake completes.
- WVALID gaps: AWLEN=1, with 3 idle cycles between beats -> exactly 2 pulses and no spurious wvalid_o.
- ARESETn asserted during beat 2 of 4 -> all outputs return to reset values immediately, with no BVALID. A subsequent single write completes normally.
